// File: rtl/milesan_mmio_pkg.sv
// Shared MMIO signalling constants, bus types and sequencer enums.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package milesan_mmio_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [63:0] data_t;
  typedef logic [7:0]  strb_t;

  localparam addr_t ADDR_STOP_SIG   = 32'h6000_0000;
  localparam addr_t ADDR_TRAP_SIG   = 32'h6000_0008;
  localparam addr_t ADDR_REG_DUMP   = 32'h6000_0010;
  localparam addr_t ADDR_FREG_DUMP  = 32'h6000_0018;
  localparam addr_t ADDR_REG_STREAM = 32'h6000_0020;

  localparam strb_t STRB_ALL = 8'hFF;

  // Dump sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LAT,
    ST_WR,
    ST_STOP,
    ST_DONE
  } state_e;

  // Owner of the write currently held on the MMIO request channel.
  typedef enum logic [1:0] {
    SRC_TRAP,
    SRC_STREAM,
    SRC_FSM
  } src_e;

endpackage

// File: rtl/mmio_stream_fifo.sv
// Synchronous FIFO of 64-bit value + 64-bit taint for the MMIO stream path.
// Latency: a pushed word is visible at head_*_o the cycle after the push.
// Backpressure: push while full is dropped (sticky overflow_o) unless a pop happens the same cycle.
// Ports: clk_i/rst_i; push_i, push_dat_i, push_t0_i; pop_i; head_* (oldest), next_* (second oldest);
//        count_o, full_o, empty_o, overflow_o.
module mmio_stream_fifo
  import milesan_mmio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [63:0]              push_dat_i,
  input  logic [63:0]              push_t0_i,
  input  logic                     pop_i,
  output logic [63:0]              head_dat_o,
  output logic [63:0]              head_t0_o,
  output logic [63:0]              next_dat_o,
  output logic [63:0]              next_t0_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  data_t         dat_mem_q [DEPTH];
  data_t         t0_mem_q  [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] rd_nxt;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          push_ok, pop_ok;

  assign full_o     = (cnt_q == FULL_CNT);
  assign empty_o    = (cnt_q == '0);
  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;
  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  assign rd_nxt     = rd_ptr_q + 1'b1;
  assign head_dat_o = dat_mem_q[rd_ptr_q];
  assign head_t0_o  = t0_mem_q[rd_ptr_q];
  assign next_dat_o = dat_mem_q[rd_nxt];
  assign next_t0_o  = t0_mem_q[rd_nxt];

  always_comb begin
    pop_ok   = pop_i && !empty_o;
    // A pop frees a slot this cycle, so a full FIFO still takes the push.
    push_ok  = push_i && (!full_o || pop_ok);
    ovf_d    = ovf_q | (push_i & ~push_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_nxt : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: empty/count gate every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      dat_mem_q[wr_ptr_q] <= push_dat_i;
      t0_mem_q[wr_ptr_q]  <= push_t0_i;
    end
  end

endmodule

// File: rtl/mmio_regdump_sequencer.sv
// MMIO initiator: dumps x1..x(NUM_XREGS-1) to the register-dump address, then writes the stop signal;
// also forwards trap pulses and buffered stream words. Latency: RD->LAT->WR, request registered.
// Backpressure: request/addr/data/taint held until mmio_gnt_i; traps, then stream, preempt the dump.
// Ports: clk_i/rst_i; start_i, trap_i; stream_valid_i/data/_t0, stream_full_o; rf_raddr_o, rf_rdata_i/_t0;
//        mmio_req/we/addr/strb/wdata (+ _t0 shadows), mmio_gnt_i; busy_o, done_o, overflow_o.
// Optional: MILESAN_REGDUMP_FREG_EN adds NUM_FREGS, frf_raddr_o, frf_rdata_i(_t0) and dumps f0..f(NUM_FREGS-1)
//           to the float-dump address after the integer registers.
module mmio_regdump_sequencer
  import milesan_mmio_pkg::*;
#(
  parameter int NUM_XREGS    = 32,
  parameter int STREAM_DEPTH = 4
`ifdef MILESAN_REGDUMP_FREG_EN
  ,
  parameter int NUM_FREGS    = 32
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        trap_i,
  input  logic        stream_valid_i,
  input  logic [63:0] stream_data_i,
  input  logic [63:0] stream_data_i_t0,
  output logic        stream_full_o,
  output logic [4:0]  rf_raddr_o,
  input  logic [63:0] rf_rdata_i,
  input  logic [63:0] rf_rdata_i_t0,
`ifdef MILESAN_REGDUMP_FREG_EN
  output logic [4:0]  frf_raddr_o,
  input  logic [63:0] frf_rdata_i,
  input  logic [63:0] frf_rdata_i_t0,
`endif
  output logic        mmio_req_o,
  input  logic        mmio_gnt_i,
  output logic        mmio_we_o,
  output logic [31:0] mmio_addr_o,
  output logic [7:0]  mmio_strb_o,
  output logic [63:0] mmio_wdata_o,
  output logic [63:0] mmio_wdata_o_t0,
  output logic        mmio_req_o_t0,
  output logic        mmio_we_o_t0,
  output logic [31:0] mmio_addr_o_t0,
  output logic [7:0]  mmio_strb_o_t0,
  output logic        busy_o,
  output logic        done_o,
  output logic        overflow_o
);

  localparam int         CW     = $clog2(STREAM_DEPTH) + 1;
  localparam logic [4:0] X_LAST = 5'(NUM_XREGS - 1);
`ifdef MILESAN_REGDUMP_FREG_EN
  localparam logic [4:0] F_LAST = 5'(NUM_FREGS - 1);
`endif

  state_e        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  data_t         cap_dat_q, cap_dat_d;
  data_t         cap_t0_q, cap_t0_d;
  logic          issued_q, issued_d;
  logic          trap_pend_q, trap_pend_d;
  logic          req_q, req_d;
  addr_t         addr_q, addr_d;
  data_t         wdata_q, wdata_d;
  data_t         wt0_q, wt0_d;
  src_e          src_q, src_d;
`ifdef MILESAN_REGDUMP_FREG_EN
  logic          freg_q, freg_d;
`endif

  logic          granted, boundary, trap_clr, fsm_gnt, fsm_offer, fsm_load;
  logic          fifo_pop, fifo_empty, stream_avail;
  logic [CW-1:0] fifo_cnt;
  data_t         head_dat, head_t0, next_dat, next_t0;
  addr_t         dump_addr;

  mmio_stream_fifo #(.DEPTH(STREAM_DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (stream_valid_i),
    .push_dat_i (stream_data_i),
    .push_t0_i  (stream_data_i_t0),
    .pop_i      (fifo_pop),
    .head_dat_o (head_dat),
    .head_t0_o  (head_t0),
    .next_dat_o (next_dat),
    .next_t0_o  (next_t0),
    .count_o    (fifo_cnt),
    .full_o     (stream_full_o),
    .empty_o    (fifo_empty),
    .overflow_o (overflow_o)
  );

  // Write-channel arbitration; a new write is chosen only when the channel is free or just granted.
  always_comb begin
    granted     = req_q & mmio_gnt_i;
    boundary    = ~req_q | mmio_gnt_i;
    trap_clr    = granted && (src_q == SRC_TRAP);
    fsm_gnt     = granted && (src_q == SRC_FSM);
    // Stream entries stay in the FIFO until granted, so the held write is the head entry.
    fifo_pop    = granted && (src_q == SRC_STREAM);
    trap_pend_d = trap_i | (trap_pend_q & ~trap_clr);
    // When the head leaves this cycle, the following entry may go straight out (back-to-back).
    stream_avail = fifo_pop ? (fifo_cnt > CW'(1)) : ~fifo_empty;
    fsm_offer   = ((state_q == ST_WR) || (state_q == ST_STOP)) && !issued_q;
    fsm_load    = 1'b0;
    req_d       = req_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wt0_d       = wt0_q;
    src_d       = src_q;
    if (boundary) begin
      if (trap_pend_q && !trap_clr) begin
        req_d   = 1'b1;
        addr_d  = ADDR_TRAP_SIG;
        wdata_d = '0;
        wt0_d   = '0;
        src_d   = SRC_TRAP;
      end else if (stream_avail) begin
        req_d   = 1'b1;
        addr_d  = ADDR_REG_STREAM;
        wdata_d = fifo_pop ? next_dat : head_dat;
        wt0_d   = fifo_pop ? next_t0 : head_t0;
        src_d   = SRC_STREAM;
      end else if (fsm_offer) begin
        req_d    = 1'b1;
        fsm_load = 1'b1;
        src_d    = SRC_FSM;
        if (state_q == ST_STOP) begin
          addr_d  = ADDR_STOP_SIG;
          wdata_d = '0;
          wt0_d   = '0;
        end else begin
          addr_d  = dump_addr;
          wdata_d = cap_dat_q;
          wt0_d   = cap_t0_q;
        end
      end else begin
        req_d = 1'b0;
      end
    end
  end

  // Dump sequencer next-state logic. The captured value waits in WR while other writes preempt it.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cap_dat_d  = cap_dat_q;
    cap_t0_d   = cap_t0_q;
    rf_raddr_o = '0;
    dump_addr  = ADDR_REG_DUMP;
    // issued_q marks that the pending FSM write already sits on the channel.
    issued_d   = fsm_gnt ? 1'b0 : (fsm_load ? 1'b1 : issued_q);
`ifdef MILESAN_REGDUMP_FREG_EN
    freg_d      = freg_q;
    frf_raddr_o = '0;
    if (freg_q) dump_addr = ADDR_FREG_DUMP;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RD;
          idx_d   = 5'd1;
`ifdef MILESAN_REGDUMP_FREG_EN
          freg_d  = 1'b0;
`endif
        end
      end
      ST_RD: begin
`ifdef MILESAN_REGDUMP_FREG_EN
        if (freg_q) frf_raddr_o = idx_q;
        else        rf_raddr_o  = idx_q;
`else
        rf_raddr_o = idx_q;
`endif
        state_d = ST_LAT;
      end
      ST_LAT: begin
`ifdef MILESAN_REGDUMP_FREG_EN
        cap_dat_d = freg_q ? frf_rdata_i : rf_rdata_i;
        cap_t0_d  = freg_q ? frf_rdata_i_t0 : rf_rdata_i_t0;
`else
        cap_dat_d = rf_rdata_i;
        cap_t0_d  = rf_rdata_i_t0;
`endif
        state_d = ST_WR;
      end
      ST_WR: begin
        if (fsm_gnt) begin
`ifdef MILESAN_REGDUMP_FREG_EN
          if (freg_q) begin
            if (idx_q == F_LAST) state_d = ST_STOP;
            else begin
              idx_d   = idx_q + 5'd1;
              state_d = ST_RD;
            end
          end else if (idx_q == X_LAST) begin
            freg_d  = 1'b1;
            idx_d   = 5'd0;
            state_d = ST_RD;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ST_RD;
          end
`else
          if (idx_q == X_LAST) begin
            state_d = ST_STOP;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ST_RD;
          end
`endif
        end
      end
      ST_STOP: begin
        if (fsm_gnt) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cap_dat_q   <= '0;
      cap_t0_q    <= '0;
      issued_q    <= 1'b0;
      trap_pend_q <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wt0_q       <= '0;
      src_q       <= SRC_FSM;
`ifdef MILESAN_REGDUMP_FREG_EN
      freg_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cap_dat_q   <= cap_dat_d;
      cap_t0_q    <= cap_t0_d;
      issued_q    <= issued_d;
      trap_pend_q <= trap_pend_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wt0_q       <= wt0_d;
      src_q       <= src_d;
`ifdef MILESAN_REGDUMP_FREG_EN
      freg_q      <= freg_d;
`endif
    end
  end

  assign mmio_req_o      = req_q;
  assign mmio_we_o       = req_q;
  assign mmio_strb_o     = req_q ? STRB_ALL : '0;
  assign mmio_addr_o     = addr_q;
  assign mmio_wdata_o    = wdata_q;
  assign mmio_wdata_o_t0 = wt0_q;
  assign mmio_req_o_t0   = 1'b0;
  assign mmio_we_o_t0    = 1'b0;
  assign mmio_addr_o_t0  = '0;
  assign mmio_strb_o_t0  = '0;
  assign busy_o          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o          = (state_q == ST_DONE);

endmodule

// File: tb/tb_mmio_regdump_sequencer.sv
// Directed bench for mmio_regdump_sequencer: dump order, taint, backpressure, trap preemption,
// stream overflow and mid-dump reset, with expected values computed here.
module tb_mmio_regdump_sequencer;
  import milesan_mmio_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, trap_i, stream_valid_i, mmio_gnt_i;
  logic [63:0] stream_data_i, stream_data_i_t0, rf_rdata_i, rf_rdata_i_t0;
  logic        stream_full_o, mmio_req_o, mmio_we_o, busy_o, done_o, overflow_o;
  logic [4:0]  rf_raddr_o;
  logic [31:0] mmio_addr_o, mmio_addr_o_t0;
  logic [7:0]  mmio_strb_o, mmio_strb_o_t0;
  logic [63:0] mmio_wdata_o, mmio_wdata_o_t0;
  logic        mmio_req_o_t0, mmio_we_o_t0;
`ifdef MILESAN_REGDUMP_FREG_EN
  logic [4:0]  frf_raddr_o;
  logic [63:0] frf_rdata_i = '0, frf_rdata_i_t0 = '0;
`endif

  int checks = 0;
  int errors = 0;
  int taint_idx = 0;

  logic [31:0] wa [64];
  logic [63:0] wd [64];
  logic [63:0] wt [64];
  int          wc [64];
  int          n_wr, unstable, bad_ctl;

  mmio_regdump_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .trap_i(trap_i),
    .stream_valid_i(stream_valid_i), .stream_data_i(stream_data_i),
    .stream_data_i_t0(stream_data_i_t0), .stream_full_o(stream_full_o),
    .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i), .rf_rdata_i_t0(rf_rdata_i_t0),
`ifdef MILESAN_REGDUMP_FREG_EN
    .frf_raddr_o(frf_raddr_o), .frf_rdata_i(frf_rdata_i), .frf_rdata_i_t0(frf_rdata_i_t0),
`endif
    .mmio_req_o(mmio_req_o), .mmio_gnt_i(mmio_gnt_i), .mmio_we_o(mmio_we_o),
    .mmio_addr_o(mmio_addr_o), .mmio_strb_o(mmio_strb_o), .mmio_wdata_o(mmio_wdata_o),
    .mmio_wdata_o_t0(mmio_wdata_o_t0), .mmio_req_o_t0(mmio_req_o_t0),
    .mmio_we_o_t0(mmio_we_o_t0), .mmio_addr_o_t0(mmio_addr_o_t0),
    .mmio_strb_o_t0(mmio_strb_o_t0), .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Register file model: x_i = i*0x1111, one-cycle read latency; only x[taint_idx] is tainted.
  always @(posedge clk_i) begin
    rf_rdata_i    <= 64'(rf_raddr_o) * 64'h1111;
    rf_rdata_i_t0 <= (taint_idx != 0 && int'(rf_raddr_o) == taint_idx) ? 64'hFF : 64'h0;
  end

  task automatic do_reset();
    rst_i = 1'b1; start_i = 1'b0; trap_i = 1'b0; mmio_gnt_i = 1'b0;
    stream_valid_i = 1'b0; stream_data_i = '0; stream_data_i_t0 = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
  endtask

  // Grants each request after 'stall' waiting cycles and logs accepted writes. Optionally pulses
  // trap_i while the dump write carrying trap_dat is stalled.
  task automatic service(input int stall, input int nwant, input logic [63:0] trap_dat, input int max_cyc);
    int hold;
    bit trapped;
    logic [31:0] sa;
    logic [63:0] sd, st;
    hold = 0; trapped = 0; n_wr = 0; unstable = 0; bad_ctl = 0;
    sa = '0; sd = '0; st = '0;
    for (int c = 0; c < max_cyc && n_wr < nwant; c++) begin
      @(negedge clk_i);
      trap_i = 1'b0;
      if (mmio_req_o) begin
        if (mmio_we_o !== 1'b1 || mmio_strb_o !== 8'hFF || mmio_req_o_t0 !== 1'b0 ||
            mmio_we_o_t0 !== 1'b0 || mmio_addr_o_t0 !== 32'h0 || mmio_strb_o_t0 !== 8'h0)
          bad_ctl++;
        if (hold == 0) begin
          sa = mmio_addr_o; sd = mmio_wdata_o; st = mmio_wdata_o_t0;
        end else if (mmio_addr_o !== sa || mmio_wdata_o !== sd || mmio_wdata_o_t0 !== st) begin
          unstable++;
        end
        if (hold == 1 && !trapped && trap_dat != 0 && mmio_addr_o == ADDR_REG_DUMP &&
            mmio_wdata_o == trap_dat) begin
          trap_i = 1'b1; trapped = 1;
        end
        if (hold == stall) begin
          mmio_gnt_i = 1'b1;
          wa[n_wr] = mmio_addr_o; wd[n_wr] = mmio_wdata_o; wt[n_wr] = mmio_wdata_o_t0; wc[n_wr] = c;
          n_wr++;
          hold = 0;
        end else begin
          mmio_gnt_i = 1'b0;
          hold++;
        end
      end else begin
        mmio_gnt_i = 1'b0;
        hold = 0;
      end
    end
    @(negedge clk_i);
    mmio_gnt_i = 1'b0;
    trap_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #1;
    checks++;
    if ({mmio_req_o, mmio_we_o, busy_o, done_o, overflow_o, stream_full_o} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 000000",
        {mmio_req_o, mmio_we_o, busy_o, done_o, overflow_o, stream_full_o});
    end
    checks++;
    if (mmio_addr_o !== 32'h0 || mmio_strb_o !== 8'h0 || rf_raddr_o !== 5'h0) begin
      errors++; $display("FAIL reset_addr got addr %h strb %h raddr %h exp all 0", mmio_addr_o, mmio_strb_o, rf_raddr_o);
    end
    checks++;
    if (mmio_wdata_o !== 64'h0 || mmio_wdata_o_t0 !== 64'h0) begin
      errors++; $display("FAIL reset_data got %h/%h exp 0/0", mmio_wdata_o, mmio_wdata_o_t0);
    end
    do_reset();
  endtask

  task automatic test_dump_taint();
    logic [63:0] e, et;
    do_reset();
    taint_idx = 5;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL dump_busy_idle got %b exp 0", busy_o); end
    pulse_start();
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL dump_busy_start got %b exp 1", busy_o); end
    service(0, 32, 64'h0, 600);
    checks++;
    if (n_wr !== 32) begin errors++; $display("FAIL dump_count got %0d exp 32", n_wr); end
    for (int i = 0; i < 31; i++) begin
      e  = 64'(i + 1) * 64'h1111;
      et = (i + 1 == 5) ? 64'hFF : 64'h0;
      checks++;
      if (wa[i] !== ADDR_REG_DUMP || wd[i] !== e || wt[i] !== et) begin
        errors++; $display("FAIL dump_x%0d got %h/%h/%h exp %h/%h/%h", i + 1, wa[i], wd[i], wt[i], ADDR_REG_DUMP, e, et);
      end
    end
    checks++;
    if (wa[31] !== ADDR_STOP_SIG || wd[31] !== 64'h0) begin
      errors++; $display("FAIL dump_stop got %h/%h exp %h/0", wa[31], wd[31], ADDR_STOP_SIG);
    end
    checks++;
    if (bad_ctl !== 0) begin errors++; $display("FAIL dump_ctl got %0d bad cycles exp 0", bad_ctl); end
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL dump_done got done %b busy %b exp 1 0", done_o, busy_o);
    end
    taint_idx = 0;
  endtask

  task automatic test_backpressure();
    do_reset();
    pulse_start();
    service(3, 32, 64'h0, 1200);
    checks++;
    if (n_wr !== 32) begin errors++; $display("FAIL bp_count got %0d exp 32", n_wr); end
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", unstable); end
    for (int i = 0; i < 31; i += 10) begin
      checks++;
      if (wa[i] !== ADDR_REG_DUMP || wd[i] !== 64'(i + 1) * 64'h1111) begin
        errors++; $display("FAIL bp_x%0d got %h/%h exp %h/%h", i + 1, wa[i], wd[i], ADDR_REG_DUMP, 64'(i + 1) * 64'h1111);
      end
    end
    checks++;
    if (wa[31] !== ADDR_STOP_SIG || done_o !== 1'b1) begin
      errors++; $display("FAIL bp_stop got %h done %b exp %h 1", wa[31], done_o, ADDR_STOP_SIG);
    end
  endtask

  task automatic test_trap_preempt();
    logic [31:0] ea;
    logic [63:0] e;
    do_reset();
    pulse_start();
    service(3, 33, 64'd10 * 64'h1111, 1400);
    checks++;
    if (n_wr !== 33) begin errors++; $display("FAIL trap_count got %0d exp 33", n_wr); end
    for (int j = 0; j < 33; j++) begin
      if (j < 10)       begin ea = ADDR_REG_DUMP; e = 64'(j + 1) * 64'h1111; end
      else if (j == 10) begin ea = ADDR_TRAP_SIG; e = 64'h0; end
      else if (j < 32)  begin ea = ADDR_REG_DUMP; e = 64'(j) * 64'h1111; end
      else              begin ea = ADDR_STOP_SIG; e = 64'h0; end
      checks++;
      if (wa[j] !== ea || wd[j] !== e) begin
        errors++; $display("FAIL trap_seq[%0d] got %h/%h exp %h/%h", j, wa[j], wd[j], ea, e);
      end
    end
  endtask

  task automatic test_stream_overflow();
    int extra;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      if (k == 4) begin
        checks++;
        if (stream_full_o !== 1'b1 || overflow_o !== 1'b0) begin
          errors++; $display("FAIL strm_full got full %b ovf %b exp 1 0", stream_full_o, overflow_o);
        end
      end
      stream_valid_i = 1'b1;
      stream_data_i = 64'hA5A5_0000_0000_0000 | 64'(k);
      stream_data_i_t0 = 64'(k) << 8;
    end
    @(negedge clk_i);
    stream_valid_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL strm_ovf got %b exp 1", overflow_o); end
    service(0, 4, 64'h0, 50);
    checks++;
    if (n_wr !== 4) begin errors++; $display("FAIL strm_count got %0d exp 4", n_wr); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wa[k] !== ADDR_REG_STREAM || wd[k] !== (64'hA5A5_0000_0000_0000 | 64'(k)) || wt[k] !== 64'(k) << 8) begin
        errors++; $display("FAIL strm_w%0d got %h/%h/%h exp %h/%h/%h", k, wa[k], wd[k], wt[k],
          ADDR_REG_STREAM, 64'hA5A5_0000_0000_0000 | 64'(k), 64'(k) << 8);
      end
    end
    checks++;
    if (wc[3] - wc[0] !== 3) begin errors++; $display("FAIL strm_b2b got span %0d exp 3", wc[3] - wc[0]); end
    extra = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (mmio_req_o) extra++;
    end
    checks++;
    if (extra !== 0 || overflow_o !== 1'b1 || stream_full_o !== 1'b0) begin
      errors++; $display("FAIL strm_drain got extra %0d ovf %b full %b exp 0 1 0", extra, overflow_o, stream_full_o);
    end
  endtask

  task automatic test_reset_mid_dump();
    bit found;
    do_reset();
    pulse_start();
    service(0, 6, 64'h0, 200);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk_i);
      if (mmio_req_o && mmio_wdata_o == 64'd7 * 64'h1111) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_x7 got no x7 request exp one"); end
    rst_i = 1'b1;
    #1;
    checks++;
    if (mmio_req_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_drop got req %b busy %b exp 0 0", mmio_req_o, busy_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    pulse_start();
    service(0, 32, 64'h0, 600);
    checks++;
    if (n_wr !== 32 || wd[0] !== 64'h1111 || wa[31] !== ADDR_STOP_SIG) begin
      errors++; $display("FAIL rstmid_restart got n %0d first %h last %h exp 32 1111 %h", n_wr, wd[0], wa[31], ADDR_STOP_SIG);
    end
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; trap_i = 1'b0; mmio_gnt_i = 1'b0;
    stream_valid_i = 1'b0; stream_data_i = '0; stream_data_i_t0 = '0;
    @(negedge clk_i);
    test_reset();
    test_dump_taint();
    test_backpressure();
    test_trap_preempt();
    test_stream_overflow();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_regdump_sequencer.md
Name: mmio_regdump_sequencer

Overview:
- Synthesizable MMIO initiator inside top_tiny_soc. It produces the signalling writes that the acquisition testbench decodes.
- On a start pulse it reads the integer register file and writes each value, with its taint, to the register-dump address. It then issues the stop-signal write.
- It also forwards trap events and a small buffered stream of core-supplied words to the trap and stream addresses.
- It drives the same mmio_* request channel and _t0 taint shadow the testbench samples.

Parameters:
- NUM_XREGS, 32, integer registers; x1..x(NUM_XREGS-1) are dumped.
- NUM_FREGS, 32, float registers; dumped only with the optional feature.
- STREAM_DEPTH, 4, stream FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  one-cycle pulse; begin dump sequence
- trap_i  in  1  one-cycle pulse; request trap-signal write
- stream_valid_i  in  1  push a stream word
- stream_data_i  in  64  stream word value
- stream_data_i_t0  in  64  stream word taint
- stream_full_o  out  1  FIFO full
- rf_raddr_o  out  5  register-file read address
- rf_rdata_i  in  64  read data, valid 1 cycle after address
- rf_rdata_i_t0  in  64  read-data taint
- mmio_req_o  out  1  write request
- mmio_gnt_i  in  1  request accepted this cycle
- mmio_we_o  out  1  always 1 while mmio_req_o is 1
- mmio_addr_o  out  32  target address
- mmio_strb_o  out  8  byte strobes; 8'hFF on every write
- mmio_wdata_o  out  64  write data
- mmio_wdata_o_t0  out  64  write-data taint
- mmio_req_o_t0, mmio_we_o_t0, mmio_addr_o_t0, mmio_strb_o_t0  out  1/1/32/8  control taint; constant 0
- busy_o  out  1  dump sequence in progress
- done_o  out  1  sticky; stop write accepted
- overflow_o  out  1  sticky; stream push dropped

Behaviour:
- Reset: every output is 0, including rf_raddr_o. FIFO is empty and pending-trap is cleared. Reset mid-transaction drops mmio_req_o immediately and the write is abandoned.
- Handshake:
  - mmio_req_o rises with addr and data already stable.
  - addr, data and taint are held unchanged until the cycle mmio_gnt_i=1.
  - req may stay asserted for a back-to-back write in the next cycle.
  - A zero-wait grant gives one write per cycle.
- FSM states: IDLE, RD, LAT, WR, STOP, DONE.
  - IDLE --start_i--> RD with idx=1. busy_o goes to 1 in the next cycle.
  - RD: drive rf_raddr_o=idx. Go to LAT.
  - LAT: capture rf_rdata_i and its _t0. Go to WR.
  - WR: write to ADDR_REG_DUMP. On grant, idx++. If idx was NUM_XREGS-1, go to STOP, otherwise to RD.
  - STOP: write 64'h0 to ADDR_STOP_SIG. On grant, go to DONE with done_o=1 and busy_o=0.
  - DONE is terminal until reset. start_i is ignored outside IDLE.
- Arbitration at each write boundary (req low, or grant this cycle), highest priority first:
  - pending trap: data 0, address ADDR_TRAP_SIG;
  - non-empty stream FIFO head: address ADDR_REG_STREAM;
  - dump FSM write.
  - While the FSM's write is preempted, the FSM holds its captured value and state.
- Trap: trap_i sets pending-trap. It is cleared when its write is granted. A second trap_i while pending is merged.
- Stream FIFO:
  - Push when stream_valid_i and not full.
  - A push while full is dropped and sets overflow_o.
  - Simultaneous push and pop on a full FIFO is accepted.
  - Pointers wrap modulo STREAM_DEPTH.
  - Count width is clog2(STREAM_DEPTH)+1.
- Streams and traps are serviced in every state, including IDLE and DONE.

Optional Feature:
- Macro: MILESAN_REGDUMP_FREG_EN.
- Defined:
  - After the last integer write, the FSM dumps f0..f(NUM_FREGS-1) to ADDR_FREG_DUMP before STOP.
  - This uses extra ports frf_raddr_o (5 bits), frf_rdata_i and frf_rdata_i_t0 (64 bits each), with the same 1-cycle read latency.
- Undefined: those ports are absent and the FSM goes WR to STOP directly.

Decomposition:
- Package milesan_mmio_pkg holds:
  - address constants ADDR_STOP_SIG=32'h60000000, ADDR_TRAP_SIG=32'h60000008, ADDR_REG_DUMP=32'h60000010, ADDR_FREG_DUMP=32'h60000018, ADDR_REG_STREAM=32'h60000020;
  - types addr_t (32 bits), data_t (64 bits), strb_t (8 bits);
  - the FSM state enum.
- One sub-module, mmio_stream_fifo: a synchronous FIFO carrying value plus taint that exports full, empty and overflow.

Test Plan:
- Dump, zero-wait grant, x1..x31 = i*0x1111: start_i -> 31 writes to 0x60000010 in ascending order, then one write to 0x60000000; done_o=1 and busy_o=0.
- Taint propagation: rf_rdata_i_t0=64'hFF for x5 only -> only the 5th dump write carries wdata_o_t0=0x00000000000000FF; all control _t0 stay 0.
- Backpressure: grant withheld 3 cycles on every write -> addr, data and _t0 held stable across each wait; sequence and count unchanged.
- Trap during dump: trap_i while the x10 write is stalled -> the x10 write completes, next write is 0x60000008 with data 0, then x11 resumes.
- Stream overflow: 5 pushes with grant held low and STREAM_DEPTH=4 -> overflow_o=1; after grant, exactly 4 writes to 0x60000020 in push order.
- Reset mid-dump: rst_i asserted during WR of x7 -> mmio_req_o=0 immediately. After release, start_i restarts at x1.
